// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM responder: word-organised array with byte-lane writes,
// configurable wait states and a two-cycle ERROR response for bad accesses.
module ahb_sram_slave #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(4) << DEPTH_LOG2;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]            state;
  logic [2:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_p1;
  logic [1:0]            lane_p1;
  logic [1:0]            size_p1;
  logic                  write_p1;
  logic [31:0]           mem [0:WORDS-1];

  logic [31:0] offset;
  logic        accept;
  logic        misaligned;
  logic        out_range;
  logic        addr_err;
  logic [3:0]  be;
  logic        wr_en;
  logic        unused_htrans;

  assign unused_htrans = HTRANS[0];

  assign HREADY = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign HRESP  = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
  assign HRDATA = ((state == ST_DATA) && !write_p1) ? mem[idx_p1] : 32'h0;

  // Address phase: decode and classify the incoming request
  assign accept     = HREADY && HSEL && HTRANS[1];
  assign offset     = HADDR - BASE_ADDR;
  assign misaligned = ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) ||
                      ((HSIZE == 3'b001) && HADDR[0]);
  // Offset compare alone would wrap for addresses below the base
  assign out_range  = (HADDR < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign addr_err   = misaligned || (HSIZE > 3'b010) || out_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      idx_p1   <= '0;
      lane_p1  <= 2'b00;
      size_p1  <= 2'b00;
      write_p1 <= 1'b0;
    end else if (accept) begin
      idx_p1   <= offset[DEPTH_LOG2+1:2];
      lane_p1  <= HADDR[1:0];
      size_p1  <= HSIZE[1:0];
      write_p1 <= HWRITE;
      if (addr_err) begin
        state <= ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state <= ST_WAIT;
        cnt   <= WAIT_LOAD;
      end else begin
        state <= ST_DATA;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 3'd0) state <= ST_DATA;
          else             cnt   <= cnt - 3'd1;
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data phase: lane enables and the committing write
  always_comb begin
    be = 4'b1111;
    case (size_p1)
      2'b00:   be = 4'b0001 << lane_p1;
      2'b01:   be = lane_p1[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign wr_en = (state == ST_DATA) && write_p1 && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_p1][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Simplified AHB-lite responder on the data bus: the memory-side end of the CPU's load/store bus master.
- Decodes an address phase and runs a data phase with configurable wait states. Serves word, halfword and byte reads/writes on byte lanes from an internal word-organised SRAM.
- Returns a two-cycle ERROR response for misaligned, oversized or out-of-range accesses.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words (1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4<<DEPTH_LOG2.
- WAIT_STATES, 1, HREADY-low cycles inserted before an OKAY data phase completes; legal range 0..7.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select from the address decoder.
- HADDR  input  32  byte address, sampled in the address phase.
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11; only NONSEQ/SEQ start a transfer.
- HWRITE  input  1  1=write, 0=read.
- HSIZE  input  3  000 byte, 001 halfword, 010 word; any other value is an error.
- HWDATA  input  32  write data, lane-positioned, valid in the data phase.
- HRDATA  output  32  full read word (no lane shifting), valid when HREADY=1 in a read data phase; 0 otherwise.
- HREADY  output  1  1 = current data phase completes this cycle and a new address phase is accepted.
- HRESP  output  2  OKAY=00, ERROR=01; RETRY/SPLIT are never issued.

Behaviour:
- Reset (sampled at the clock edge):
  - Outputs: state=IDLE, HREADY=1, HRESP=OKAY, HRDATA=0.
  - Latched address, size and write flags are cleared.
  - SRAM contents are not cleared.
  - Reset asserted mid-transfer aborts the transfer; a pending write is discarded.
- Address phase accepted on an edge where HREADY=1 && HSEL=1 && HTRANS[1]=1.
  - Latch word index = (HADDR-BASE_ADDR)>>2, HADDR[1:0], HSIZE and HWRITE.
  - Evaluate error = misaligned (word with HADDR[1:0]!=0, or halfword with HADDR[0]=1) OR HSIZE>2 OR HADDR outside [BASE_ADDR, BASE_ADDR+4<<DEPTH_LOG2).
- Otherwise (HSEL=0, IDLE/BUSY, or HREADY=0): nothing is latched and the state stays or returns to IDLE.
- States:
  - IDLE: HREADY=1, HRESP=OKAY.
    - Accepted + error -> ERR1.
    - Accepted + WAIT_STATES>0 -> WAIT, with the counter loaded to WAIT_STATES-1.
    - Accepted + WAIT_STATES=0 -> DATA.
  - WAIT: HREADY=0, HRESP=OKAY. The counter decrements each cycle; at 0 -> DATA.
  - DATA: HREADY=1, HRESP=OKAY. The transfer completes this cycle.
    - Read: HRDATA = SRAM[index], read combinationally from the latched index.
    - Write: on the closing edge, write the byte lanes of HWDATA selected by the byte enables.
    - A new accepted address phase in the same cycle goes directly to ERR1/WAIT/DATA as from IDLE (back-to-back pipelining). Otherwise -> IDLE.
  - ERR1: HREADY=0, HRESP=ERROR -> ERR2.
  - ERR2: HREADY=1, HRESP=ERROR. No SRAM write and HRDATA=0. An accepted address phase is handled as in DATA; otherwise -> IDLE.
- Byte enables:
  - Byte: 1<<HADDR[1:0].
  - Halfword: 0011 if HADDR[1]=0, else 1100.
  - Word: 1111.
- Write-then-read to the same word back-to-back: the read returns the new data, because the write commits on the edge ending the write's DATA cycle and the read samples the array in its own later data phase.
- Latency for an OKAY transfer: WAIT_STATES+1 cycles from address acceptance to HREADY=1. With WAIT_STATES=0, full throughput is one transfer per cycle.
- HWDATA is ignored outside the DATA cycle of a write.

Test Plan:
- Reset with WAIT_STATES=1 -> HREADY=1, HRESP=00, HRDATA=0. Then NONSEQ word write 32'hDEADBEEF @0x10 followed by a word read @0x10 -> each data phase is 1 cycle HREADY=0 then HREADY=1; the read returns 32'hDEADBEEF with HRESP=00.
- Byte write 8'hAA @0x13 (HWDATA=32'hAA00_0000), halfword write 16'h5555 @0x10 (HWDATA=32'h0000_5555), then word read @0x10 -> 32'hAA??5555 with byte 2 unchanged from 32'hDEADBEEF: 32'hAAAD5555.
- Word read @0x02, halfword read @0x01, HSIZE=3'b011, and word access @BASE_ADDR+0x1000 -> each gives cycle 1 HREADY=0/HRESP=01 and cycle 2 HREADY=1/HRESP=01; no SRAM change, checked by a follow-up read @0x00.
- WAIT_STATES=0: back-to-back NONSEQ write @0x20=32'h1 and read @0x20 on consecutive cycles -> HREADY stays 1 throughout and the read returns 32'h1 one cycle after its address phase.
- HSEL=0 or HTRANS=IDLE/BUSY with a valid address -> no transfer; HREADY=1, HRESP=00, HRDATA=0, memory unchanged.
- Assert reset during the WAIT cycle of a write of 32'hFFFFFFFF @0x30 -> next cycle HREADY=1, HRESP=00, and a later read @0x30 returns the old value.
